// File: rtl/gate_state_mac_if.sv
// Load/compute/readback bundle between the loader FSM (master) and the complex
// matrix-vector engine (slave); start is a single-cycle request, no backpressure.
interface gate_state_mac_if #(
    parameter int N = 2,
    parameter int W = 8
);
    localparam int MAX = 2 ** N;

    logic                   start;
    logic [MAX*W-1:0]       state_re;
    logic [MAX*W-1:0]       state_im;
    logic [MAX*MAX*W-1:0]   gate_re;
    logic [MAX*MAX*W-1:0]   gate_im;
    logic                   busy;
    logic                   done;
    logic [MAX*W-1:0]       out_re;
    logic [MAX*W-1:0]       out_im;
    logic                   ovf;

    modport master (
        output start, state_re, state_im, gate_re, gate_im,
        input  busy, done, out_re, out_im, ovf
    );

    modport slave (
        input  start, state_re, state_im, gate_re, gate_im,
        output busy, done, out_re, out_im, ovf
    );
endinterface

// File: rtl/gate_state_mac.sv
// out = G*s with one time-multiplexed complex MAC; done pulses MAX*(MAX+1) cycles
// after the start edge. No backpressure: start is ignored while busy, never queued.
module gate_state_mac #(
    parameter int N    = 2,
    parameter int W    = 8,
    parameter int FRAC = 6
) (
    input  logic             clk,
    input  logic             reset,
    gate_state_mac_if.slave  bus
);
    localparam int MAX = 2 ** N;
    localparam int AW  = 2 * W + N + 1;
    localparam logic signed [AW-1:0] HALF = AW'(2 ** (FRAC - 1));
    localparam logic signed [AW-1:0] MAXV = AW'((2 ** (W - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);

    typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

    state_t               st;
    logic [N-1:0]         row;
    logic [N-1:0]         k;
    logic signed [W-1:0]  g_re_m [MAX*MAX];
    logic signed [W-1:0]  g_im_m [MAX*MAX];
    logic signed [W-1:0]  s_re_m [MAX];
    logic signed [W-1:0]  s_im_m [MAX];
    logic signed [AW-1:0] acc_re, acc_im;
    logic [MAX*W-1:0]     shadow_re, shadow_im;

    function automatic logic signed [AW-1:0] sx(input logic signed [W-1:0] v);
        return {{(AW-W){v[W-1]}}, v};
    endfunction

    // Returns {clamped, saturated value}.
    function automatic logic [W:0] sat(input logic signed [AW-1:0] v);
        if (v > MAXV)      return {1'b1, MAXV[W-1:0]};
        else if (v < MINV) return {1'b1, MINV[W-1:0]};
        else               return {1'b0, v[W-1:0]};
    endfunction

    logic [2*N-1:0]       idx;
    logic signed [AW-1:0] term_re, term_im, rnd_re, rnd_im;
    logic [W:0]           sat_re, sat_im;
    logic [MAX*W-1:0]     shadow_nxt_re, shadow_nxt_im;

    always_comb begin
        idx     = {row, k};
        term_re = sx(g_re_m[idx]) * sx(s_re_m[k]) - sx(g_im_m[idx]) * sx(s_im_m[k]);
        term_im = sx(g_re_m[idx]) * sx(s_im_m[k]) + sx(g_im_m[idx]) * sx(s_re_m[k]);
        rnd_re  = (acc_re + HALF) >>> FRAC;
        rnd_im  = (acc_im + HALF) >>> FRAC;
        sat_re  = sat(rnd_re);
        sat_im  = sat(rnd_im);
        shadow_nxt_re = shadow_re;
        shadow_nxt_im = shadow_im;
        shadow_nxt_re[row*W +: W] = sat_re[W-1:0];
        shadow_nxt_im[row*W +: W] = sat_im[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            row        <= '0;
            k          <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            shadow_re  <= '0;
            shadow_im  <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.out_re <= '0;
            bus.out_im <= '0;
            for (int i = 0; i < MAX * MAX; i++) begin
                g_re_m[i] <= '0;
                g_im_m[i] <= '0;
            end
            for (int i = 0; i < MAX; i++) begin
                s_re_m[i] <= '0;
                s_im_m[i] <= '0;
            end
        end else begin
            bus.done <= 1'b0;
            case (st)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < MAX * MAX; i++) begin
                            g_re_m[i] <= bus.gate_re[i*W +: W];
                            g_im_m[i] <= bus.gate_im[i*W +: W];
                        end
                        for (int i = 0; i < MAX; i++) begin
                            s_re_m[i] <= bus.state_re[i*W +: W];
                            s_im_m[i] <= bus.state_im[i*W +: W];
                        end
                        row      <= '0;
                        k        <= '0;
                        acc_re   <= '0;
                        acc_im   <= '0;
                        bus.ovf  <= 1'b0;
                        bus.busy <= 1'b1;
                        st       <= MAC;
                    end
                end
                MAC: begin
                    acc_re <= acc_re + term_re;
                    acc_im <= acc_im + term_im;
                    if (k == N'(MAX - 1)) st <= WRITE;
                    else                  k  <= k + N'(1);
                end
                WRITE: begin
                    shadow_re <= shadow_nxt_re;
                    shadow_im <= shadow_nxt_im;
                    if (sat_re[W] || sat_im[W]) bus.ovf <= 1'b1;
                    acc_re <= '0;
                    acc_im <= '0;
                    k      <= '0;
                    if (row == N'(MAX - 1)) begin
                        bus.out_re <= shadow_nxt_re;
                        bus.out_im <= shadow_nxt_im;
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        st         <= IDLE;
                    end else begin
                        row <= row + N'(1);
                        st  <= MAC;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
